// File: rtl/life_logic.sv
// ---------------------------------------------------------------------------------------------
// life_logic: Conway generation engine between the generation timer and double_buffer.
// On a step request it sweeps every cell of the toroidal board. For each cell it reads the
// 3x3 neighbourhood from the front buffer and writes the next-generation state to the back
// buffer. At the end of the sweep it pulses swap/done and increments the generation count.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-low reset
//   step_in           one-cycle request for one generation (honoured only when idle)
//   logic_data_r_in   front-buffer read data, valid READ_LAT cycles after its address
//   logic_addr_r_out  front-buffer read address (y*BOARD_W + x)
//   logic_addr_w_out  back-buffer write address
//   logic_data_w_out  next-generation cell state
//   logic_wr_en_out   back-buffer write strobe, one cycle per cell
//   swap_out          one-cycle buffer swap pulse
//   busy_out          high while a generation is in progress
//   done_out          one-cycle pulse coincident with swap_out
//   gen_out           completed-generation count (wrapping)
// ---------------------------------------------------------------------------------------------
module life_logic #(
   parameter int unsigned BOARD_W  = 64,
   parameter int unsigned BOARD_H  = 48,
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned GEN_W    = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              step_in,
   input  logic              logic_data_r_in,
   output logic [ADDR_W-1:0] logic_addr_r_out,
   output logic [ADDR_W-1:0] logic_addr_w_out,
   output logic              logic_data_w_out,
   output logic              logic_wr_en_out,
   output logic              swap_out,
   output logic              busy_out,
   output logic              done_out,
   output logic [GEN_W-1:0]  gen_out
);

   localparam int unsigned XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
   localparam int unsigned YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
   localparam int unsigned DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [XW-1:0] XLast = XW'(BOARD_W - 1);
   localparam logic [YW-1:0] YLast = YW'(BOARD_H - 1);

   typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StSwap} state_e;

   state_e            state_q, state_d;
   logic [XW-1:0]     x_q, x_d, x_nx;
   logic [YW-1:0]     y_q, y_d, y_nx;
   logic [3:0]        k_q, k_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [3:0]        n_q, n_d;
   logic              alive_q, alive_d;
   logic              last_cell;
   // Tag pipeline tracking which returned datum is valid and which one is the centre cell.
   logic [READ_LAT-1:0] pv_q, pv_d, pc_q, pc_d;
   logic [READ_LAT:0]   pv_ext, pc_ext;
   logic                push, push_center;

   logic [ADDR_W-1:0] addr_r_q, addr_r_d, addr_w_q, addr_w_d;
   logic              data_w_q, data_w_d, wr_en_q, wr_en_d;
   logic              swap_q, swap_d, busy_q, busy_d, done_q, done_d;
   logic [GEN_W-1:0]  gen_q, gen_d;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [XW-1:0] cx,
                                                   input logic [YW-1:0] cy);
      return ADDR_W'(cy) * ADDR_W'(BOARD_W) + ADDR_W'(cx);
   endfunction

   // Address of neighbour k (row-major over dy then dx, each in -1..+1) with toroidal wrap.
   function automatic logic [ADDR_W-1:0] nb_addr(input logic [XW-1:0] cx,
                                                 input logic [YW-1:0] cy,
                                                 input logic [3:0]    k);
      logic [XW-1:0] xm, xp, nx;
      logic [YW-1:0] ym, yp, ny;
      xm = (cx == '0) ? XLast : cx - 1'b1;
      xp = (cx == XLast) ? '0 : cx + 1'b1;
      ym = (cy == '0) ? YLast : cy - 1'b1;
      yp = (cy == YLast) ? '0 : cy + 1'b1;
      case (k)
         4'd0, 4'd3, 4'd6: nx = xm;
         4'd1, 4'd4, 4'd7: nx = cx;
         default:          nx = xp;
      endcase
      case (k)
         4'd0, 4'd1, 4'd2: ny = ym;
         4'd3, 4'd4, 4'd5: ny = cy;
         default:          ny = yp;
      endcase
      return cell_addr(nx, ny);
   endfunction

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      k_d         = k_q;
      dcnt_d      = dcnt_q;
      n_d         = n_q;
      alive_d     = alive_q;
      addr_r_d    = addr_r_q;
      addr_w_d    = addr_w_q;
      data_w_d    = data_w_q;
      wr_en_d     = 1'b0;
      swap_d      = 1'b0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      gen_d       = gen_q;
      push        = 1'b0;
      push_center = 1'b0;

      x_nx      = (x_q == XLast) ? '0 : x_q + 1'b1;
      y_nx      = (x_q != XLast) ? y_q : ((y_q == YLast) ? '0 : y_q + 1'b1);
      last_cell = (x_q == XLast) && (y_q == YLast);

      // Capture the datum whose address went out READ_LAT cycles ago.
      if ((state_q == StRead || state_q == StDrain) && pv_q[READ_LAT-1]) begin
         if (pc_q[READ_LAT-1]) begin
            alive_d = logic_data_r_in;
         end else begin
            n_d = n_q + {3'b000, logic_data_r_in};
         end
      end

      case (state_q)
         StIdle: begin
            if (step_in) begin
               state_d  = StRead;
               x_d      = '0;
               y_d      = '0;
               k_d      = 4'd0;
               n_d      = 4'd0;
               busy_d   = 1'b1;
               addr_r_d = nb_addr('0, '0, 4'd0);
            end
         end
         StRead: begin
            push        = 1'b1;
            push_center = (k_q == 4'd4);
            if (k_q == 4'd8) begin
               state_d = StDrain;
               dcnt_d  = '0;
            end else begin
               k_d      = k_q + 4'd1;
               addr_r_d = nb_addr(x_q, y_q, k_q + 4'd1);
            end
         end
         StDrain: begin
            if (dcnt_q == DW'(READ_LAT - 1)) begin
               // Uses the post-capture count so the final datum is included.
               state_d  = StWrite;
               wr_en_d  = 1'b1;
               addr_w_d = cell_addr(x_q, y_q);
               data_w_d = (n_d == 4'd3) | (alive_d & (n_d == 4'd2));
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         StWrite: begin
            if (last_cell) begin
               state_d = StSwap;
               swap_d  = 1'b1;
               done_d  = 1'b1;
               gen_d   = gen_q + GEN_W'(1);
            end else begin
               state_d  = StRead;
               x_d      = x_nx;
               y_d      = y_nx;
               k_d      = 4'd0;
               n_d      = 4'd0;
               addr_r_d = nb_addr(x_nx, y_nx, 4'd0);
            end
         end
         StSwap: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      pv_ext = {pv_q, push};
      pc_ext = {pc_q, push_center};
      pv_d   = pv_ext[READ_LAT-1:0];
      pc_d   = pc_ext[READ_LAT-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         k_q      <= '0;
         dcnt_q   <= '0;
         n_q      <= '0;
         alive_q  <= 1'b0;
         pv_q     <= '0;
         pc_q     <= '0;
         addr_r_q <= '0;
         addr_w_q <= '0;
         data_w_q <= 1'b0;
         wr_en_q  <= 1'b0;
         swap_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gen_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         k_q      <= k_d;
         dcnt_q   <= dcnt_d;
         n_q      <= n_d;
         alive_q  <= alive_d;
         pv_q     <= pv_d;
         pc_q     <= pc_d;
         addr_r_q <= addr_r_d;
         addr_w_q <= addr_w_d;
         data_w_q <= data_w_d;
         wr_en_q  <= wr_en_d;
         swap_q   <= swap_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         gen_q    <= gen_d;
      end
   end

   assign logic_addr_r_out = addr_r_q;
   assign logic_addr_w_out = addr_w_q;
   assign logic_data_w_out = data_w_q;
   assign logic_wr_en_out  = wr_en_q;
   assign swap_out         = swap_q;
   assign busy_out         = busy_q;
   assign done_out         = done_q;
   assign gen_out          = gen_q;

endmodule

// File: tb/tb_life_logic.sv
// ---------------------------------------------------------------------------------------------
// tb_life_logic: self-checking bench for life_logic on an 8x8 board with a behavioural
// double_buffer (one-cycle registered read from front, write to back, copy on swap).
// Board patterns are 64-bit vectors with bit index y*8 + x.
// ---------------------------------------------------------------------------------------------
module tb_life_logic;

   localparam int unsigned BW = 8;
   localparam int unsigned BH = 8;
   localparam int unsigned AW = 6;
   localparam int unsigned GW = 16;

   logic          clk = 1'b0;
   logic          rst_in;
   logic          step_in;
   logic          rd_data;
   logic [AW-1:0] addr_r, addr_w;
   logic          data_w, wr_en, swap_out, busy_out, done_out;
   logic [GW-1:0] gen_out;

   life_logic #(
      .BOARD_W  (BW),
      .BOARD_H  (BH),
      .ADDR_W   (AW),
      .READ_LAT (1),
      .GEN_W    (GW)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst_in),
      .step_in          (step_in),
      .logic_data_r_in  (rd_data),
      .logic_addr_r_out (addr_r),
      .logic_addr_w_out (addr_w),
      .logic_data_w_out (data_w),
      .logic_wr_en_out  (wr_en),
      .swap_out         (swap_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .gen_out          (gen_out)
   );

   always #5 clk = ~clk;

   // Behavioural double_buffer plus event counters (counters are only ever incremented here).
   logic [63:0] front;
   logic [63:0] back = '0;
   int          wr_cnt = 0;
   int          nz_cnt = 0;
   int          swap_cnt = 0;

   always @(posedge clk) begin
      rd_data <= front[addr_r];
      if (wr_en === 1'b1) begin
         back[addr_w] <= data_w;
         wr_cnt <= wr_cnt + 1;
         if (data_w === 1'b1) nz_cnt <= nz_cnt + 1;
      end
      if (swap_out === 1'b1) begin
         front = back;
         swap_cnt <= swap_cnt + 1;
      end
   end

   typedef struct {
      string       name;
      logic [63:0] init;
      logic [63:0] exp_b;
   } vec_t;

   vec_t        vecs[6];
   int          checks = 0;
   int          errors = 0;
   logic [AW-1:0] ra[9];
   logic [AW-1:0] first_wa;
   int          exp_ra[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse step and follow the generation until swap; returns cycles from busy rise to swap.
   task automatic run_gen(input bit inject, output int lat);
      int c;
      bit got_wa;
      step_in = 1'b1;
      @(negedge clk);
      step_in = 1'b0;
      chk("busy_rise", 64'(busy_out), 64'd1);
      c = 0;
      got_wa = 1'b0;
      while (c < 2000 && swap_out !== 1'b1) begin
         if (c < 9) ra[c] = addr_r;
         if (!got_wa && wr_en === 1'b1) begin
            first_wa = addr_w;
            got_wa   = 1'b1;
         end
         step_in = inject && (c == 10 || c == 400);
         @(negedge clk);
         c++;
      end
      step_in = 1'b0;
      lat = c;
      chk("swap_seen", 64'(swap_out), 64'd1);
      chk("swap_done_busy", 64'({done_out, busy_out}), 64'b11);
      @(negedge clk);
      chk("after_swap", 64'({swap_out, done_out, busy_out}), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [GW-1:0] g0;
      int          s0, w0, nz0;

      vecs[0] = '{"blinker", (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28),
                  (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35)};
      vecs[1] = '{"torus_block", (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63),
                  (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63)};
      vecs[2] = '{"mid_block", (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36),
                  (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36)};
      vecs[3] = '{"single", 64'd1 << 45, 64'd0};
      vecs[4] = '{"wrap_blinker", (64'd1 << 56) | (64'd1 << 0) | (64'd1 << 8),
                  (64'd1 << 7) | (64'd1 << 0) | (64'd1 << 1)};
      vecs[5] = '{"empty", 64'd0, 64'd0};
      exp_ra = '{63, 56, 57, 7, 0, 1, 15, 8, 9};

      rst_in  = 1'b0;
      step_in = 1'b0;
      front   = '0;

      // Reset held with step toggling.
      for (int i = 0; i < 5; i++) begin
         step_in = (i % 2 == 1);
         @(negedge clk);
         chk("reset_ctrl", 64'({wr_en, swap_out, busy_out, done_out}), 64'd0);
         chk("reset_gen", 64'(gen_out), 64'd0);
      end
      chk("reset_addr", 64'({addr_r, addr_w, data_w}), 64'd0);
      chk("reset_nowr", 64'(wr_cnt), 64'd0);
      step_in = 1'b0;
      rst_in  = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 64'(busy_out), 64'd0);

      // Table of board patterns, one generation each.
      for (int v = 0; v < 6; v++) begin
         front = vecs[v].init;
         g0 = gen_out;
         s0 = swap_cnt;
         w0 = wr_cnt;
         run_gen(1'b0, lat);
         chk({vecs[v].name, "_back"}, back, vecs[v].exp_b);
         chk({vecs[v].name, "_lat"}, 64'(lat), 64'd704);
         chk({vecs[v].name, "_gen"}, 64'(gen_out), 64'(g0 + 16'd1));
         chk({vecs[v].name, "_writes"}, 64'(wr_cnt - w0), 64'd64);
         chk({vecs[v].name, "_swaps"}, 64'(swap_cnt - s0), 64'd1);
      end
      for (int i = 0; i < 9; i++) begin
         chk("nb_addr_cell0", 64'(ra[i]), 64'(exp_ra[i]));
      end

      // Extra step requests during a generation are ignored.
      front = vecs[0].init;
      g0 = gen_out;
      s0 = swap_cnt;
      run_gen(1'b1, lat);
      chk("ignore_lat", 64'(lat), 64'd704);
      chk("ignore_gen", 64'(gen_out), 64'(g0 + 16'd1));
      repeat (30) @(negedge clk);
      chk("ignore_idle", 64'(busy_out), 64'd0);
      chk("ignore_swaps", 64'(swap_cnt - s0), 64'd1);
      chk("ignore_back", back, vecs[0].exp_b);

      // Reset in the middle of a generation.
      s0 = swap_cnt;
      step_in = 1'b1;
      @(negedge clk);
      step_in = 1'b0;
      repeat (300) @(negedge clk);
      chk("midrst_busy", 64'(busy_out), 64'd1);
      chk("midrst_noswap", 64'(swap_cnt), 64'(s0));
      rst_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_outs", 64'({wr_en, swap_out, busy_out, done_out}), 64'd0);
      chk("midrst_gen", 64'(gen_out), 64'd0);
      w0 = wr_cnt;
      rst_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_nowr", 64'(wr_cnt), 64'(w0));
      chk("midrst_noswap2", 64'(swap_cnt), 64'(s0));
      front = vecs[2].init;
      run_gen(1'b0, lat);
      chk("midrst_first_waddr", 64'(first_wa), 64'd0);
      chk("midrst_first_raddr", 64'(ra[0]), 64'd63);
      chk("midrst_gen1", 64'(gen_out), 64'd1);
      chk("midrst_back", back, vecs[2].exp_b);

      // Empty board for three consecutive generations from a fresh reset.
      rst_in = 1'b0;
      @(negedge clk);
      rst_in = 1'b1;
      @(negedge clk);
      front = '0;
      s0  = swap_cnt;
      w0  = wr_cnt;
      nz0 = nz_cnt;
      for (int g = 0; g < 3; g++) begin
         run_gen(1'b0, lat);
      end
      chk("empty3_gen", 64'(gen_out), 64'd3);
      chk("empty3_swaps", 64'(swap_cnt - s0), 64'd3);
      chk("empty3_writes", 64'(wr_cnt - w0), 64'd192);
      chk("empty3_nonzero", 64'(nz_cnt - nz0), 64'd0);
      chk("empty3_back", back, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
